// File: rtl/pc_hazard_ctrl_if.sv
// rtl/pc_hazard_ctrl_if.sv - ID/EX hazard inputs and PC / pipeline-register control outputs
// master drives the pipeline-side inputs; slave is the hazard controller.
interface pc_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic [1:0]  id_fp_op;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        pc_jump;
  logic        pc_src;
  logic        pc_write_enable;
  logic [31:0] pc_jump_address;
  logic [31:0] pc_branch_address;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_hold;
  logic        fp_busy;

  modport master (
    output id_rs, id_rt, id_jump, id_jump_target, id_fp_op,
           ex_mem_read, ex_rt, ex_branch_taken, ex_branch_target,
    input  pc_jump, pc_src, pc_write_enable, pc_jump_address, pc_branch_address,
           ifid_write, ifid_flush, idex_flush, idex_hold, fp_busy
  );

  modport slave (
    input  id_rs, id_rt, id_jump, id_jump_target, id_fp_op,
           ex_mem_read, ex_rt, ex_branch_taken, ex_branch_target,
    output pc_jump, pc_src, pc_write_enable, pc_jump_address, pc_branch_address,
           ifid_write, ifid_flush, idex_flush, idex_hold, fp_busy
  );
endinterface

// File: rtl/pc_hazard_ctrl.sv
// rtl/pc_hazard_ctrl.sv - PC redirect, load-use bubble and multi-cycle FP stall control
// Only the FSM state and the FP busy down-counter are registered; all outputs are combinational.
module pc_hazard_ctrl #(
  parameter int unsigned FP_ADD_LAT = 3,
  parameter int unsigned FP_MUL_LAT = 4,
  parameter int unsigned FP_DIV_LAT = 8
) (
  input logic            clk,
  input logic            reset,
  pc_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    FP_BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fp_lat;
  logic       load_use;

  always_comb begin
    fp_lat = 4'd1;
    case (bus.id_fp_op)
      2'b01:   fp_lat = 4'(FP_ADD_LAT);
      2'b10:   fp_lat = 4'(FP_MUL_LAT);
      2'b11:   fp_lat = 4'(FP_DIV_LAT);
      default: fp_lat = 4'd1;
    endcase
  end

  // r0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

  assign bus.pc_jump_address   = bus.id_jump_target;
  assign bus.pc_branch_address = bus.ex_branch_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    bus.pc_jump         = 1'b0;
    bus.pc_src          = 1'b0;
    bus.pc_write_enable = 1'b1;
    bus.ifid_write      = 1'b1;
    bus.ifid_flush      = 1'b0;
    bus.idex_flush      = 1'b0;
    bus.idex_hold       = 1'b0;
    bus.fp_busy         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ex_branch_taken) begin
          bus.pc_src     = 1'b1;
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
        end else if (bus.id_jump) begin
          bus.pc_jump    = 1'b1;
          bus.ifid_flush = 1'b1;
        end else if (load_use) begin
          bus.pc_write_enable = 1'b0;
          bus.ifid_write      = 1'b0;
          bus.idex_flush      = 1'b1;
        end else if ((bus.id_fp_op != 2'b00) && (fp_lat > 4'd1)) begin
          // The issue cycle itself counts toward latency, so busy spans LAT-1 cycles.
          state_d = FP_BUSY;
          cnt_d   = fp_lat - 4'd2;
        end
      end
      FP_BUSY: begin
        bus.pc_write_enable = 1'b0;
        bus.ifid_write      = 1'b0;
        bus.idex_hold       = 1'b1;
        bus.fp_busy         = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// tb/tb_pc_hazard_ctrl.sv - directed vector bench for pc_hazard_ctrl
// Output word order: {pc_jump, pc_src, pc_write_enable, ifid_write, ifid_flush, idex_flush, idex_hold, fp_busy}.
module tb_pc_hazard_ctrl;

  localparam logic [7:0] DEF  = 8'b0011_0000;
  localparam logic [7:0] BR   = 8'b0111_1100;
  localparam logic [7:0] JMP  = 8'b1011_1000;
  localparam logic [7:0] LU   = 8'b0000_0100;
  localparam logic [7:0] BUSY = 8'b0000_0011;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        jump;
    logic [31:0] jt;
    logic [1:0]  fp;
    logic        mr;
    logic [4:0]  ert;
    logic        br;
    logic [31:0] bt;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[12];

  pc_hazard_ctrl_if bus ();

  pc_hazard_ctrl #(
    .FP_ADD_LAT(3),
    .FP_MUL_LAT(4),
    .FP_DIV_LAT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic jump,
                              input logic [31:0] jt, input logic [1:0] fp, input logic mr,
                              input logic [4:0] ert, input logic br, input logic [31:0] bt,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.rs = rs; v.rt = rt; v.jump = jump; v.jt = jt; v.fp = fp;
    v.mr = mr; v.ert = ert; v.br = br; v.bt = bt; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.pc_jump, bus.pc_src, bus.pc_write_enable, bus.ifid_write,
            bus.ifid_flush, bus.idex_flush, bus.idex_hold, bus.fp_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs            = v.rs;
    bus.id_rt            = v.rt;
    bus.id_jump          = v.jump;
    bus.id_jump_target   = v.jt;
    bus.id_fp_op         = v.fp;
    bus.ex_mem_read      = v.mr;
    bus.ex_rt            = v.ert;
    bus.ex_branch_taken  = v.br;
    bus.ex_branch_target = v.bt;
  endtask

  // One cycle of hand-written sequence: inputs change on the falling edge, checked 1ns later.
  task automatic cyc(input logic [1:0] fp, input logic br, input logic mr, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [7:0] exp, input string name);
    @(negedge clk);
    drive(mk(rs, 5'd0, 1'b0, 32'h0, fp, mr, ert, br, 32'h44, exp, name));
    #1;
    chk(name, {24'h0, outs()}, {24'h0, exp});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "zero"));

    vecs[0]  = mk(5'd0, 5'd0, 0, 32'h0,   2'b00, 0, 5'd0, 0, 32'h0,   DEF, "idle_defaults");
    vecs[1]  = mk(5'd1, 5'd2, 1, 32'h80,  2'b00, 0, 5'd0, 1, 32'h40,  BR,  "branch_vs_jump");
    vecs[2]  = mk(5'd1, 5'd2, 1, 32'h123, 2'b00, 0, 5'd0, 0, 32'h0,   JMP, "jump_only");
    vecs[3]  = mk(5'd0, 5'd5, 0, 32'h0,   2'b00, 1, 5'd5, 0, 32'h0,   LU,  "load_use_rt");
    vecs[4]  = mk(5'd0, 5'd5, 0, 32'h0,   2'b00, 0, 5'd5, 0, 32'h0,   DEF, "load_use_cleared");
    vecs[5]  = mk(5'd0, 5'd0, 0, 32'h0,   2'b00, 1, 5'd0, 0, 32'h0,   DEF, "load_r0_no_stall");
    vecs[6]  = mk(5'd7, 5'd1, 0, 32'h0,   2'b00, 1, 5'd7, 0, 32'h0,   LU,  "load_use_rs");
    vecs[7]  = mk(5'd3, 5'd4, 0, 32'h0,   2'b00, 1, 5'd7, 0, 32'h0,   DEF, "load_no_match");
    vecs[8]  = mk(5'd7, 5'd7, 1, 32'h10,  2'b11, 1, 5'd7, 1, 32'hABC, BR,  "branch_over_all");
    vecs[9]  = mk(5'd7, 5'd7, 1, 32'h20,  2'b11, 1, 5'd7, 0, 32'h0,   JMP, "jump_over_lu_fp");
    vecs[10] = mk(5'd0, 5'd0, 0, 32'h0,   2'b00, 0, 5'd0, 0, 32'h0,   DEF, "no_fp_after_jump");
    vecs[11] = mk(5'd9, 5'd9, 0, 32'hFFFF_FFFF, 2'b00, 0, 5'd0, 1, 32'hFFFF_FFFC, BR, "branch_max_addr");

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {24'h0, outs()}, {24'h0, DEF});
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, "_outs"},  {24'h0, outs()}, {24'h0, vecs[i].exp});
      chk({vecs[i].name, "_jaddr"}, bus.pc_jump_address, vecs[i].jt);
      chk({vecs[i].name, "_baddr"}, bus.pc_branch_address, vecs[i].bt);
    end

    // FP multiply, latency 4; a branch in busy cycle 2 is ignored
    cyc(2'b10, 0, 0, 5'd0, 5'd0, DEF,  "mul_c0_issue");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "mul_c1");
    cyc(2'b00, 1, 0, 5'd0, 5'd0, BUSY, "mul_c2_branch_ignored");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "mul_c3");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, DEF,  "mul_c4_free");

    // Back-to-back: add (3) then mul waiting in ID
    cyc(2'b01, 0, 0, 5'd0, 5'd0, DEF,  "b2b_c0_add_issue");
    cyc(2'b10, 0, 0, 5'd0, 5'd0, BUSY, "b2b_c1");
    cyc(2'b10, 0, 0, 5'd0, 5'd0, BUSY, "b2b_c2");
    cyc(2'b10, 0, 0, 5'd0, 5'd0, DEF,  "b2b_c3_mul_issue");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "b2b_c4");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "b2b_c5");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "b2b_c6");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, DEF,  "b2b_c7_free");

    // Load-use hazard holds back an FP add for one cycle
    cyc(2'b01, 0, 1, 5'd5, 5'd5, LU,   "lufp_c0_stall");
    cyc(2'b01, 0, 0, 5'd5, 5'd5, DEF,  "lufp_c1_issue");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "lufp_c2");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "lufp_c3");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, DEF,  "lufp_c4_free");

    // Divide interrupted by asynchronous reset in busy cycle 3
    cyc(2'b11, 0, 0, 5'd0, 5'd0, DEF,  "div_c0_issue");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "div_c1");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "div_c2");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, BUSY, "div_c3");
    reset = 1'b1;
    #1;
    chk("div_async_reset", {24'h0, outs()}, {24'h0, DEF});
    @(negedge clk);
    #1;
    chk("div_in_reset", {24'h0, outs()}, {24'h0, DEF});
    reset = 1'b0;
    cyc(2'b00, 0, 0, 5'd0, 5'd0, DEF,  "div_after_reset");
    cyc(2'b00, 0, 0, 5'd0, 5'd0, DEF,  "div_stays_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
